// File: rtl/systolic_output_collector.sv
// Drain-side collector for the systolic array: deskews column results
// into aligned rows and queues them in a first-word fall-through FIFO.
module systolic_output_collector #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*DATA_W-1:0]       col_data,
  input  logic [N-1:0]              col_valid,
  output logic [N*DATA_W-1:0]       out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      skew_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = N * DATA_W;

  logic [N-1:0][DATA_W-1:0] al_data;
  logic [N-1:0]             al_valid;

  // Column j is delayed N-1-j cycles so every column of a row lines up
  // with the last column, which arrives last and passes straight through.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int S = N - 1 - j;
    if (S == 0) begin : g_pass
      assign al_data[j]  = col_data[j*DATA_W +: DATA_W];
      assign al_valid[j] = col_valid[j];
    end else begin : g_dly
      logic [DATA_W-1:0] d_q [S];
      logic [S-1:0]      v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < S; k++) d_q[k] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= col_data[j*DATA_W +: DATA_W];
          v_q[0] <= col_valid[j];
          for (int k = 1; k < S; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
          end
        end
      end

      assign al_data[j]  = d_q[S-1];
      assign al_valid[j] = v_q[S-1];
    end
  end

  logic          row_valid;
  logic          skew;
  logic          push;
  logic          pop;
  logic          drop;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          skew_q, skew_d;
  logic [RW-1:0] mem_q [DEPTH];

  assign row_valid = &al_valid;
  assign skew      = (|al_valid) & ~row_valid;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign skew_err  = skew_q;

  assign pop  = out_valid & out_ready;
  // A pop frees the slot this cycle, so a full FIFO can still accept.
  assign push = row_valid & (~full | pop);
  assign drop = row_valid & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;
    skew_d   = skew_q | skew;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      skew_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      skew_q   <= skew_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= al_data;
  end

  assign out_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_systolic_output_collector.sv
// Scoreboard bench for systolic_output_collector: directed skewed rows,
// expected rows queued at issue and checked by a separate pop monitor.
module tb_systolic_output_collector;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int DP = 4;
  localparam int RW = N * DW;
  localparam int CW = $clog2(DP) + 1;

  logic          clk;
  logic          rst;
  logic [RW-1:0] col_data;
  logic [N-1:0]  col_valid;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          skew_err;

  systolic_output_collector #(.N(N), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_data  (col_data),
    .col_valid (col_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .skew_err  (skew_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  bit stream_on = 0;
  bit saw_full  = 0;

  logic [RW-1:0] sb [$];

  // Injection history: slot s holds the row started s cycles ago.
  bit            hv [N+1];
  bit            hl [N+1];
  logic [RW-1:0] hd [N+1];

  task automatic chk(input string nm, input logic [RW-1:0] got,
                     input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int k);
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = 16'(k*16 + j);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (stream_on && full) saw_full = 1;
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop got=%h exp=none", out_data);
        end else begin
          chk("pop_data", out_data, sb.pop_front());
        end
      end
    end
  end

  task automatic clr_hist();
    for (int s = 0; s <= N; s++) begin
      hv[s] = 0;
      hl[s] = 0;
      hd[s] = '0;
    end
  endtask

  // Drive one cycle; late delays column 2 of the new row by one cycle.
  task automatic step(input bit st, input logic [RW-1:0] row,
                      input bit late, input bit rdy);
    for (int s = N; s > 0; s--) begin
      hv[s] = hv[s-1];
      hl[s] = hl[s-1];
      hd[s] = hd[s-1];
    end
    hv[0] = st;
    hl[0] = late;
    hd[0] = row;
    col_data  = '0;
    col_valid = '0;
    for (int j = 0; j < N; j++) begin
      for (int s = 0; s <= N; s++) begin
        if (hv[s] && s == ((hl[s] && j == 2) ? j + 1 : j)) begin
          col_valid[j]         = 1'b1;
          col_data[j*DW +: DW] = hd[s][j*DW +: DW];
        end
      end
    end
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(0, '0, 0, rdy);
  endtask

  task automatic do_reset();
    rst = 1;
    sb.delete();
    clr_hist();
    col_data  = '0;
    col_valid = '0;
    out_ready = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    rst       = 1;
    col_data  = '0;
    col_valid = '0;
    out_ready = 0;
    clr_hist();
    #2;
    chk("rst_empty", RW'(empty), RW'(1));
    chk("rst_full", RW'(full), RW'(0));
    chk("rst_valid", RW'(out_valid), RW'(0));
    chk("rst_count", RW'(count), RW'(0));
    chk("rst_data", out_data, '0);
    chk("rst_flags", RW'({overflow, skew_err}), RW'(0));
    @(posedge clk);
    #1;
    rst = 0;

    // Single row
    step(1, 64'h0044_0033_0022_0011, 0, 0);
    idle(2, 0);
    chk("single_lat3", RW'(out_valid), RW'(0));
    idle(1, 0);
    chk("single_valid", RW'(out_valid), RW'(1));
    chk("single_data", out_data, 64'h0044_0033_0022_0011);
    chk("single_count", RW'(count), RW'(1));
    sb.push_back(64'h0044_0033_0022_0011);
    idle(1, 1);
    chk("single_empty", RW'(empty), RW'(1));
    chk("single_zero", out_data, '0);

    // Fill, overflow, drain, wrap
    for (int k = 1; k <= 5; k++) step(1, mk(k), 0, 0);
    idle(3, 0);
    chk("fill_full", RW'(full), RW'(1));
    chk("fill_count", RW'(count), RW'(4));
    chk("fill_ovf", RW'(overflow), RW'(1));
    for (int k = 1; k <= 4; k++) sb.push_back(mk(k));
    idle(4, 1);
    chk("drain_empty", RW'(empty), RW'(1));
    for (int k = 6; k <= 8; k++) step(1, mk(k), 0, 0);
    idle(3, 0);
    chk("wrap_count", RW'(count), RW'(3));
    for (int k = 6; k <= 8; k++) sb.push_back(mk(k));
    idle(3, 1);
    chk("wrap_empty", RW'(empty), RW'(1));

    // Full with simultaneous push and pop
    do_reset();
    for (int k = 9; k <= 13; k++) step(1, mk(k), 0, 0);
    idle(2, 0);
    chk("pp_full", RW'(full), RW'(1));
    for (int k = 9; k <= 13; k++) sb.push_back(mk(k));
    idle(1, 1);
    chk("pp_count", RW'(count), RW'(4));
    chk("pp_ovf", RW'(overflow), RW'(0));
    idle(4, 0);
    chk("pp_count_hold", RW'(count), RW'(4));
    idle(4, 1);
    chk("pp_empty", RW'(empty), RW'(1));

    // Skew error
    step(1, mk(14), 1, 0);
    idle(5, 0);
    chk("skew_flag", RW'(skew_err), RW'(1));
    chk("skew_count", RW'(count), RW'(0));
    step(1, mk(15), 0, 0);
    idle(3, 0);
    chk("skew_next_count", RW'(count), RW'(1));
    sb.push_back(mk(15));
    idle(1, 1);

    // Reset mid-operation
    step(1, mk(16), 0, 0);
    step(1, mk(17), 0, 0);
    idle(3, 0);
    chk("mid_count2", RW'(count), RW'(2));
    step(1, mk(18), 0, 0);
    step(0, '0, 0, 0);
    #3;
    rst = 1;
    #1;
    chk("mid_empty", RW'(empty), RW'(1));
    chk("mid_count", RW'(count), RW'(0));
    chk("mid_data", out_data, '0);
    chk("mid_flags", RW'({overflow, skew_err}), RW'(0));
    clr_hist();
    col_data  = '0;
    col_valid = '0;
    @(posedge clk);
    #3;
    rst = 0;
    @(posedge clk);
    #1;
    idle(6, 1);
    chk("mid_no_phantom", RW'(empty), RW'(1));
    step(1, mk(19), 0, 0);
    idle(2, 0);
    chk("mid_lat3", RW'(out_valid), RW'(0));
    idle(1, 0);
    chk("mid_lat4", RW'(out_valid), RW'(1));
    sb.push_back(mk(19));
    idle(1, 1);

    // Streaming
    pops = 0;
    stream_on = 1;
    for (int k = 0; k < 16; k++) sb.push_back(mk(k));
    for (int c = 0; c < 22; c++) begin
      step(c < 16, mk(c), 0, 1);
      chk("stream_valid", RW'(out_valid), RW'((c + 1 >= 4) && (c + 1 <= 19)));
    end
    stream_on = 0;
    chk("stream_pops", RW'(pops), RW'(16));
    chk("stream_nofull", RW'(saw_full), RW'(0));
    chk("sb_drained", RW'(sb.size()), RW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
